param_sync_fifo: RTL and testbench
==================================

// Module: param_sync_fifo
// PURPOSE
//  Parametrised single-clock FIFO that succeeds the fixed FIFO behind f_interface.
//  Adds generic width/depth, runtime almost-full/almost-empty thresholds, an occupancy count,
//  and sticky overflow/underflow error flags. First-word-fall-through mode is optional.
//  Sits between the UVM driver-side write port and the consumer; it is the DUT for the FIFO environment.
// PARAMETERS
//  DATA_W  8   data word width in bits (>=1)
//  DEPTH   16  number of entries; must be a power of 2 and >=4 (elaboration error otherwise)
//  AW      $clog2(DEPTH)  derived pointer width; not overridable
// PORTS
//  clk             in   1       rising-edge clock
//  reset           in   1       asynchronous, active-low reset
//  i_wrdata        in   DATA_W  write data
//  i_wren          in   1       write request
//  i_rden          in   1       read request
//  i_alm_full_th   in   AW+1    almost-full threshold (entries)
//  i_alm_empty_th  in   AW+1    almost-empty threshold (entries)
//  i_clr_err       in   1       synchronous clear of the sticky error flags
//  o_rddata        out  DATA_W  read data
//  o_full          out  1       count == DEPTH
//  o_empty         out  1       count == 0 (FWFT: no word presented)
//  o_alm_full      out  1       count >= i_alm_full_th
//  o_alm_empty     out  1       count <= i_alm_empty_th
//  o_count         out  AW+1    occupancy, 0..DEPTH
//  o_overflow      out  1       sticky: write requested while write not accepted
//  o_underflow     out  1       sticky: read requested while read not accepted
// BEHAVIOUR
//  - Reset (reset==0, async): pointers=0, count=0, o_empty=1, o_alm_empty=1. All other outputs are 0, including o_rddata.
//    Memory contents are not reset. A reset mid-transfer discards all stored data immediately.
//  - rd_acc = i_rden & ~o_empty. wr_acc = i_wren & (~o_full | rd_acc): a write when full is accepted only with a same-cycle read.
//  - Read when empty is always rejected, even with a same-cycle write. There is no bypass in standard mode.
//  - count_next = count + wr_acc - rd_acc. Pointers are AW bits wide and wrap naturally at DEPTH.
//  - All flags and o_count are registered and computed from count_next.
//    They reflect the post-edge occupancy at the same edge that performs the operation.
//  - Thresholds are sampled every cycle. A threshold change shows on the flags at the next edge.
//    Thresholds > DEPTH are legal: o_alm_full is then never set and o_alm_empty is always set.
//  - Standard read latency is 1: rd_acc at edge N -> o_rddata valid after edge N.
//    o_rddata holds its value until the next rd_acc.
//  - Errors: o_overflow sets on i_wren & ~wr_acc; o_underflow sets on i_rden & ~rd_acc.
//    i_clr_err clears both. If set and clear occur in the same cycle, set wins.
//  - Simultaneous wr_acc and rd_acc at count==0 cannot occur (read is rejected).
//    At count==DEPTH, wr_acc and rd_acc together leave count unchanged and o_full stays 1.
// CONFIGURATION
//  FIFO_FWFT_EN defined: the head word appears on o_rddata with no read request.
//    o_empty deasserts 1 cycle after the first write into an empty FIFO (write->data latency 1).
//    i_rden acts as a pop/acknowledge and the next word is presented after the same edge.
//    o_count includes the presented word.
//  FIFO_FWFT_EN undefined: standard 1-cycle registered read, as described in BEHAVIOUR.
// STRUCTURE
//  - fifo_pkg holds the defaults FIFO_DATA_W_DEF and FIFO_DEPTH_DEF.
//    It also holds typedef fifo_status_t, a packed struct of full, empty, alm_full, alm_empty, overflow and underflow.
//    The environment's interface and monitors share this package.
//  - Sub-module fifo_dpram holds the storage: 1 write port and 1 read port,
//    synchronous write, and registered read in standard mode / combinational read in FWFT mode.
//  - The top level holds pointers, count, flag logic and error logic.
// TESTING (DATA_W=8, DEPTH=16, thresholds af=14, ae=2)
//  - Reset release, then 16 writes 0x00..0x0F -> o_alm_full at count 14, o_full at 16, o_count=16;
//    16 reads return 0x00..0x0F in order, o_empty=1 after the last one.
//  - Full FIFO plus a 17th write alone -> write dropped, o_overflow=1, count stays 16;
//    i_clr_err pulse -> o_overflow=0.
//  - Full FIFO plus simultaneous wren and rden -> count stays 16, the head is read,
//    the new word lands at the tail, no overflow.
//  - Empty FIFO plus simultaneous wren(0xA5) and rden -> read rejected, o_underflow=1, count=1;
//    the next read returns 0xA5.
//  - Wrap-around: 40 interleaved writes/reads at count ~8 -> data order intact across 2+ pointer wraps;
//    change ae 2->10 mid-run -> o_alm_empty follows at the next edge.
//  - Assert reset with count=9 -> o_count=0 and o_empty=1 immediately (async);
//    FWFT build: write 0x3C to an empty FIFO -> o_rddata=0x3C and o_empty=0 one cycle later with no rden.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: parameter defaults and the status bundle used by the
// FIFO, its interface and the monitors.
package fifo_pkg;

    localparam int FIFO_DATA_W_DEF = 8;
    localparam int FIFO_DEPTH_DEF  = 16;

    typedef struct packed {
        logic full;
        logic empty;
        logic alm_full;
        logic alm_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    localparam fifo_status_t FIFO_STATUS_RST = '{
        full:      1'b0,
        empty:     1'b1,
        alm_full:  1'b0,
        alm_empty: 1'b1,
        overflow:  1'b0,
        underflow: 1'b0
    };

endpackage

// File: rtl/fifo_dpram.sv
// FIFO storage: one write port, one read port. Registered read by default;
// combinational (fall-through) read when FIFO_FWFT_EN is defined.
module fifo_dpram #(
    parameter int DATA_W = 8,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int DEPTH = 1 << AW;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

`ifdef FIFO_FWFT_EN
    // i_rd_en means "a word is present"; the output is zeroed otherwise and during reset.
    assign o_rd_data = (reset & i_rd_en) ? r_mem[i_rd_addr] : '0;
`else
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;
`endif

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, runtime thresholds and
// sticky error flags. Define FIFO_FWFT_EN for first-word-fall-through reads.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter  int DATA_W = FIFO_DATA_W_DEF,
    parameter  int DEPTH  = FIFO_DEPTH_DEF,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_wrdata,
    input  logic              i_wren,
    input  logic              i_rden,
    input  logic [AW:0]       i_alm_full_th,
    input  logic [AW:0]       i_alm_empty_th,
    input  logic              i_clr_err,
    output logic [DATA_W-1:0] o_rddata,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_alm_full,
    output logic              o_alm_empty,
    output logic [AW:0]       o_count,
    output logic              o_overflow,
    output logic              o_underflow
);

    generate
        if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("param_sync_fifo: DEPTH must be a power of 2 and >= 4");
        end
    endgenerate

    localparam logic [AW:0] L_FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    fifo_status_t  r_status;

    logic          w_wr_acc;
    logic          w_rd_acc;
    logic [AW:0]   w_count_next;
    fifo_status_t  w_status_next;
    logic          w_mem_rd_en;

    // A write into a full FIFO is only accepted when a read frees a slot in the same cycle.
    assign w_rd_acc     = i_rden & ~r_status.empty;
    assign w_wr_acc     = i_wren & (~r_status.full | w_rd_acc);
    assign w_count_next = r_count + (AW + 1)'(w_wr_acc) - (AW + 1)'(w_rd_acc);

    always_comb begin
        w_status_next           = r_status;
        w_status_next.full      = (w_count_next == L_FULL_CNT);
        w_status_next.empty     = (w_count_next == '0);
        w_status_next.alm_full  = (w_count_next >= i_alm_full_th);
        w_status_next.alm_empty = (w_count_next <= i_alm_empty_th);
        // Setting takes priority over a simultaneous clear.
        w_status_next.overflow  = (i_wren & ~w_wr_acc) | (r_status.overflow  & ~i_clr_err);
        w_status_next.underflow = (i_rden & ~w_rd_acc) | (r_status.underflow & ~i_clr_err);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_status <= FIFO_STATUS_RST;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count  <= w_count_next;
            r_status <= w_status_next;
        end
    end

`ifdef FIFO_FWFT_EN
    assign w_mem_rd_en = ~r_status.empty;
`else
    assign w_mem_rd_en = w_rd_acc;
`endif

    fifo_dpram #(
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_dpram (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (i_wrdata),
        .i_rd_en   (w_mem_rd_en),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (o_rddata)
    );

    assign o_full      = r_status.full;
    assign o_empty     = r_status.empty;
    assign o_alm_full  = r_status.alm_full;
    assign o_alm_empty = r_status.alm_empty;
    assign o_overflow  = r_status.overflow;
    assign o_underflow = r_status.underflow;
    assign o_count     = r_count;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo (DATA_W=8, DEPTH=16);
// covers both the standard build and the FIFO_FWFT_EN build.
module tb_param_sync_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] i_wrdata;
    logic       i_wren;
    logic       i_rden;
    logic [4:0] i_alm_full_th;
    logic [4:0] i_alm_empty_th;
    logic       i_clr_err;
    logic [7:0] o_rddata;
    logic       o_full;
    logic       o_empty;
    logic       o_alm_full;
    logic       o_alm_empty;
    logic [4:0] o_count;
    logic       o_overflow;
    logic       o_underflow;

    int n_checks;
    int n_fail;

    param_sync_fifo #(
        .DATA_W (8),
        .DEPTH  (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_wrdata       (i_wrdata),
        .i_wren         (i_wren),
        .i_rden         (i_rden),
        .i_alm_full_th  (i_alm_full_th),
        .i_alm_empty_th (i_alm_empty_th),
        .i_clr_err      (i_clr_err),
        .o_rddata       (o_rddata),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .o_alm_full     (o_alm_full),
        .o_alm_empty    (o_alm_empty),
        .o_count        (o_count),
        .o_overflow     (o_overflow),
        .o_underflow    (o_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock with the given requests; outputs are valid on return (1 time unit after the edge).
    task automatic op(input logic wr, input logic rd, input logic [7:0] wd);
        i_wren   = wr;
        i_rden   = rd;
        i_wrdata = wd;
        @(posedge clk);
        #1;
        i_wren   = 1'b0;
        i_rden   = 1'b0;
        i_clr_err = 1'b0;
    endtask

    // Read (optionally with a write) and return the word the read delivered.
    task automatic pop(input logic wr, input logic [7:0] wd, output logic [7:0] rd_data);
`ifdef FIFO_FWFT_EN
        rd_data = o_rddata;
        op(wr, 1'b1, wd);
`else
        op(wr, 1'b1, wd);
        rd_data = o_rddata;
`endif
    endtask

    task automatic test_reset;
        reset = 1'b0;
        i_wren = 1'b0; i_rden = 1'b0; i_wrdata = 8'h00; i_clr_err = 1'b0;
        i_alm_full_th = 5'd14; i_alm_empty_th = 5'd2;
        #12;
        n_checks++;
        if ({o_count, o_empty, o_alm_empty, o_full, o_alm_full, o_overflow, o_underflow} !== {5'd0, 6'b110000}) begin
            n_fail++;
            $display("FAIL reset_flags: got cnt=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b expected cnt=0 e=1 ae=1 others 0",
                     o_count, o_empty, o_alm_empty, o_full, o_alm_full, o_overflow, o_underflow);
        end
        n_checks++;
        if (o_rddata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rddata: got %h expected 00", o_rddata);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        $display("reset released");
    endtask

    task automatic test_fill_drain;
        logic [7:0] d;
        for (int i = 0; i < 16; i++) begin
            op(1'b1, 1'b0, 8'(i));
            n_checks++;
            if ({o_count, o_alm_full, o_full, o_alm_empty} !== {5'(i + 1), (i + 1 >= 14), (i + 1 == 16), (i + 1 <= 2)}) begin
                n_fail++;
                $display("FAIL fill_%0d: got cnt=%0d af=%b f=%b ae=%b expected cnt=%0d af=%b f=%b ae=%b",
                         i, o_count, o_alm_full, o_full, o_alm_empty, i + 1, (i + 1 >= 14), (i + 1 == 16), (i + 1 <= 2));
            end
`ifndef FIFO_FWFT_EN
            if (i == 0) begin
                n_checks++;
                if (o_rddata !== 8'h00) begin
                    n_fail++;
                    $display("FAIL no_bypass: got %h expected 00", o_rddata);
                end
            end
`endif
        end
        $display("fill: count=%0d full=%b", o_count, o_full);
        for (int i = 0; i < 16; i++) begin
            pop(1'b0, 8'h00, d);
            n_checks++;
            if ({d, o_count, o_empty} !== {8'(i), 5'(15 - i), (i == 15)}) begin
                n_fail++;
                $display("FAIL drain_%0d: got data=%h cnt=%0d e=%b expected data=%h cnt=%0d e=%b",
                         i, d, o_count, o_empty, 8'(i), 15 - i, (i == 15));
            end
        end
        $display("drain: count=%0d empty=%b", o_count, o_empty);
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 8'(8'h20 + i));
        op(1'b1, 1'b0, 8'hEE);
        n_checks++;
        if ({o_count, o_full, o_overflow, o_underflow} !== {5'd16, 3'b110}) begin
            n_fail++;
            $display("FAIL overflow_set: got cnt=%0d f=%b ov=%b un=%b expected cnt=16 f=1 ov=1 un=0",
                     o_count, o_full, o_overflow, o_underflow);
        end
        i_clr_err = 1'b1;
        op(1'b0, 1'b0, 8'h00);
        n_checks++;
        if ({o_overflow, o_count} !== {1'b0, 5'd16}) begin
            n_fail++;
            $display("FAIL overflow_clear: got ov=%b cnt=%0d expected ov=0 cnt=16", o_overflow, o_count);
        end
        i_alm_full_th = 5'd17;
        op(1'b0, 1'b0, 8'h00);
        n_checks++;
        if (o_alm_full !== 1'b0) begin
            n_fail++;
            $display("FAIL af_above_depth: got af=%b expected 0", o_alm_full);
        end
        i_alm_full_th = 5'd14;
        op(1'b0, 1'b0, 8'h00);
        n_checks++;
        if (o_alm_full !== 1'b1) begin
            n_fail++;
            $display("FAIL af_restore: got af=%b expected 1", o_alm_full);
        end
        $display("overflow: count=%0d ov=%b", o_count, o_overflow);
    endtask

    task automatic test_full_rw;
        logic [7:0] d;
        pop(1'b1, 8'h77, d);
        n_checks++;
        if ({d, o_count, o_full, o_overflow} !== {8'h20, 5'd16, 2'b10}) begin
            n_fail++;
            $display("FAIL full_rw: got data=%h cnt=%0d f=%b ov=%b expected data=20 cnt=16 f=1 ov=0",
                     d, o_count, o_full, o_overflow);
        end
        for (int i = 0; i < 16; i++) begin
            pop(1'b0, 8'h00, d);
            n_checks++;
            if (d !== ((i == 15) ? 8'h77 : 8'(8'h21 + i))) begin
                n_fail++;
                $display("FAIL full_rw_drain_%0d: got %h expected %h", i, d, ((i == 15) ? 8'h77 : 8'(8'h21 + i)));
            end
        end
        $display("full_rw: drained, count=%0d", o_count);
    endtask

    task automatic test_underflow;
        logic [7:0] d;
        op(1'b1, 1'b1, 8'hA5);
        n_checks++;
        if ({o_underflow, o_count, o_empty} !== {1'b1, 5'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL underflow_set: got un=%b cnt=%0d e=%b expected un=1 cnt=1 e=0", o_underflow, o_count, o_empty);
        end
`ifndef FIFO_FWFT_EN
        n_checks++;
        if (o_rddata !== 8'h77) begin
            n_fail++;
            $display("FAIL rddata_hold: got %h expected 77", o_rddata);
        end
`endif
        pop(1'b0, 8'h00, d);
        n_checks++;
        if ({d, o_count, o_empty} !== {8'hA5, 5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL underflow_next_read: got data=%h cnt=%0d e=%b expected data=a5 cnt=0 e=1", d, o_count, o_empty);
        end
        i_clr_err = 1'b1;
        op(1'b0, 1'b1, 8'h00);
        n_checks++;
        if (o_underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL set_beats_clear: got un=%b expected 1", o_underflow);
        end
        i_clr_err = 1'b1;
        op(1'b0, 1'b0, 8'h00);
        n_checks++;
        if (o_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_clear: got un=%b expected 0", o_underflow);
        end
        $display("underflow: done, count=%0d", o_count);
    endtask

    task automatic test_wrap;
        logic [7:0] d;
        for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 40; i++) begin
            if (i == 20) i_alm_empty_th = 5'd10;
            pop(1'b1, 8'(8 + i), d);
            n_checks++;
            if ({d, o_count, o_alm_empty} !== {8'(i), 5'd8, (i >= 20)}) begin
                n_fail++;
                $display("FAIL wrap_%0d: got data=%h cnt=%0d ae=%b expected data=%h cnt=8 ae=%b",
                         i, d, o_count, o_alm_empty, 8'(i), (i >= 20));
            end
        end
        i_alm_empty_th = 5'd2;
        $display("wrap: 40 transfers, count=%0d", o_count);
    endtask

    task automatic test_async_reset;
        op(1'b1, 1'b0, 8'h99);
        n_checks++;
        if (o_count !== 5'd9) begin
            n_fail++;
            $display("FAIL pre_reset_count: got %0d expected 9", o_count);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({o_count, o_empty, o_alm_empty, o_full} !== {5'd0, 3'b110}) begin
            n_fail++;
            $display("FAIL async_reset: got cnt=%0d e=%b ae=%b f=%b expected cnt=0 e=1 ae=1 f=0",
                     o_count, o_empty, o_alm_empty, o_full);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        $display("async reset: count=%0d empty=%b", o_count, o_empty);
    endtask

    task automatic test_post_reset_write;
        op(1'b1, 1'b0, 8'h3C);
`ifdef FIFO_FWFT_EN
        n_checks++;
        if ({o_rddata, o_empty, o_count} !== {8'h3C, 1'b0, 5'd1}) begin
            n_fail++;
            $display("FAIL fwft_present: got data=%h e=%b cnt=%0d expected data=3c e=0 cnt=1", o_rddata, o_empty, o_count);
        end
`else
        n_checks++;
        if ({o_rddata, o_empty, o_count} !== {8'h00, 1'b0, 5'd1}) begin
            n_fail++;
            $display("FAIL std_no_fallthrough: got data=%h e=%b cnt=%0d expected data=00 e=0 cnt=1", o_rddata, o_empty, o_count);
        end
`endif
        $display("post-reset write: data=%h empty=%b", o_rddata, o_empty);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_rw();
        test_underflow();
        test_wrap();
        test_async_reset();
        test_post_reset_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
